i2s_clock_gen: RTL and testbench

I2S_CLOCK_GEN -- requirements
Module: i2s_clock_gen

---
 rtl/i2s_clock_pkg.sv | 29 ++
 rtl/clk_div_stage.sv | 57 +++++
 rtl/i2s_clock_gen.sv | 127 ++++++++++++
 tb/tb_i2s_clock_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_clock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_clock_pkg -- state encoding and divisor defaults for i2s_clock_gen
// Revision: 1.0
// ---------------------------------------------------------------------------
package i2s_clock_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_e;

  localparam int unsigned MCLK_DIV_DEFAULT = 4;
  localparam int unsigned BCLK_DIV_DEFAULT = 4;
  localparam int unsigned FRAME_DEFAULT    = 64;
  localparam int unsigned MIN_DIV          = 2;

  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  // Frames hold an even number of bit clocks so LRCLK stays 50/50.
  function automatic int unsigned clamp_frame(input int unsigned v);
    return clamp_div(v) & ~32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_stage -- wrapping 0..D-1 counter with registered level and edge strobes
// Revision: 1.0
// ---------------------------------------------------------------------------
module clk_div_stage #(
  parameter int W = 16
) (
  input  logic         clock_in,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] count,
  output logic         level,
  output logic         wrap,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] count_q, count_d;
  logic         level_q, level_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;

  assign wrap = advance && (count_q == divisor - 1'b1);

  always_comb begin
    count_d = count_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      level_d = 1'b0;
    end else if (advance) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      // Level tracks the count it will be shown with, so strobes line up with the edge.
      level_d = (count_d >= (divisor >> 1));
      rise_d  = level_d & ~level_q;
      fall_d  = ~level_d & level_q;
    end
  end

  always_ff @(posedge clock_in) begin
    count_q <= count_d;
    level_q <= level_d;
    rise_q  <= rise_d;
    fall_q  <= fall_d;
  end

  assign count = count_q;
  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2s_clock_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_clock_gen -- MCLK/BCLK/LRCLK generator with frame-aligned reconfiguration
// Revision: 1.0
// ---------------------------------------------------------------------------
module i2s_clock_gen
  import i2s_clock_pkg::*;
#(
  parameter int          DIV_W        = 16,
  parameter int          FRAME_W      = 8,
  parameter int unsigned MCLK_DIV_DEF = MCLK_DIV_DEFAULT,
  parameter int unsigned BCLK_DIV_DEF = BCLK_DIV_DEFAULT,
  parameter int unsigned FRAME_DEF    = FRAME_DEFAULT
) (
  input  logic               clock_in,
  input  logic               Reset,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   mclk_div,
  input  logic [DIV_W-1:0]   bclk_div,
  input  logic [FRAME_W-1:0] frame_len,
  output logic               mclk_out,
  output logic               bclk_out,
  output logic               lrclk_out,
  output logic               bclk_rise,
  output logic               bclk_fall,
  output logic               frame_start,
  output logic               running
);

  localparam logic [DIV_W-1:0]   MDIV_RST  = DIV_W'(clamp_div(MCLK_DIV_DEF));
  localparam logic [DIV_W-1:0]   BDIV_RST  = DIV_W'(clamp_div(BCLK_DIV_DEF));
  localparam logic [FRAME_W-1:0] FRAME_RST = FRAME_W'(clamp_frame(FRAME_DEF));

  state_e state_q, state_d;

  logic [DIV_W-1:0]   mdiv_q, bdiv_q, mdiv_sh_q, bdiv_sh_q;
  logic [FRAME_W-1:0] flen_q, flen_sh_q;
  logic               pending_q, cfg_ready_q, frame_start_q, running_q;

  logic               stage_clear, run_en, boundary, accept, promote;
  logic               m_wrap, b_wrap, l_wrap;
  logic               m_rise, m_fall, l_rise, l_fall;
  logic [DIV_W-1:0]   m_count, b_count;
  logic [FRAME_W-1:0] l_count;
  logic               unused_taps;

  assign run_en      = (state_q != S_IDLE);
  assign stage_clear = Reset || (state_q == S_IDLE);
  assign boundary    = l_wrap;
  assign accept      = cfg_valid && cfg_ready_q;
  assign promote     = pending_q && ((state_q == S_IDLE) || boundary);

  clk_div_stage #(.W(DIV_W)) u_mclk (
    .clock_in (clock_in), .clear (stage_clear), .advance (run_en), .divisor (mdiv_q),
    .count (m_count), .level (mclk_out), .wrap (m_wrap), .rise (m_rise), .fall (m_fall)
  );

  clk_div_stage #(.W(DIV_W)) u_bclk (
    .clock_in (clock_in), .clear (stage_clear), .advance (m_wrap), .divisor (bdiv_q),
    .count (b_count), .level (bclk_out), .wrap (b_wrap), .rise (bclk_rise), .fall (bclk_fall)
  );

  clk_div_stage #(.W(FRAME_W)) u_lrclk (
    .clock_in (clock_in), .clear (stage_clear), .advance (b_wrap), .divisor (flen_q),
    .count (l_count), .level (lrclk_out), .wrap (l_wrap), .rise (l_rise), .fall (l_fall)
  );

  assign unused_taps = ^{m_count, b_count, l_count, m_rise, m_fall, l_rise, l_fall};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (en) state_d = S_RUN;
      S_RUN:      if (!en) state_d = S_STOPPING;
      S_STOPPING: begin
        if (en)            state_d = S_RUN;
        else if (boundary) state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock_in) begin
    if (Reset) begin
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
      pending_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
      mdiv_sh_q     <= '0;
      bdiv_sh_q     <= '0;
      flen_sh_q     <= '0;
      mdiv_q        <= MDIV_RST;
      bdiv_q        <= BDIV_RST;
      flen_q        <= FRAME_RST;
    end else begin
      frame_start_q <= ((state_q == S_IDLE) && en) || (boundary && (state_d != S_IDLE));
      running_q     <= (state_d != S_IDLE);
      // promote uses the old pending flag, so an offer taken on a boundary waits a frame.
      if (promote) begin
        mdiv_q      <= mdiv_sh_q;
        bdiv_q      <= bdiv_sh_q;
        flen_q      <= flen_sh_q;
        pending_q   <= 1'b0;
        cfg_ready_q <= 1'b1;
      end else if (accept) begin
        mdiv_sh_q   <= DIV_W'(clamp_div(32'(mclk_div)));
        bdiv_sh_q   <= DIV_W'(clamp_div(32'(bclk_div)));
        flen_sh_q   <= FRAME_W'(clamp_frame(32'(frame_len)));
        pending_q   <= 1'b1;
        cfg_ready_q <= 1'b0;
      end
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_clock_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2s_clock_gen -- vector table, directed corner sequences and a random run vs. frame-index model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_i2s_clock_gen;

  logic        clock_in = 1'b0;
  logic        Reset = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [15:0] mclk_div = '0, bclk_div = '0;
  logic [7:0]  frame_len = '0;
  logic        cfg_ready, mclk_out, bclk_out, lrclk_out, bclk_rise, bclk_fall, frame_start, running;
  logic [7:0]  dut_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_in = ~clock_in;

  i2s_clock_gen dut (
    .clock_in (clock_in), .Reset (Reset), .en (en), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .mclk_div (mclk_div), .bclk_div (bclk_div), .frame_len (frame_len),
    .mclk_out (mclk_out), .bclk_out (bclk_out), .lrclk_out (lrclk_out),
    .bclk_rise (bclk_rise), .bclk_fall (bclk_fall), .frame_start (frame_start), .running (running)
  );

  assign dut_out = {cfg_ready, running, frame_start, mclk_out, bclk_out, lrclk_out, bclk_rise, bclk_fall};

  // Reference model: position in the frame as a plain cycle index t.
  int m_mode = 0, m_t = 0, m_dm = 4, m_db = 4, m_f = 64, s_dm = 0, s_db = 0, s_f = 0;
  bit m_pend = 0, m_fs = 0, m_prevb = 0, m_sok = 0;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int clampf(input int v);
    return clampd(v) & ~1;
  endfunction

  function automatic bit exp_bclk();
    if (m_mode == 0) return 1'b0;
    return ((m_t / m_dm) % m_db) >= (m_db / 2);
  endfunction

  function automatic logic [7:0] model_out();
    bit mc, bc, lc;
    mc = (m_mode != 0) && ((m_t % m_dm) >= (m_dm / 2));
    bc = exp_bclk();
    lc = (m_mode != 0) && (((m_t / (m_dm * m_db)) % m_f) >= (m_f / 2));
    return {!m_pend, m_mode != 0, m_fs, mc, bc, lc, m_sok & bc & !m_prevb, m_sok & !bc & m_prevb};
  endfunction

  task automatic model_step();
    bit bnd, acc, prom, curb;
    int nxt;
    curb = exp_bclk();
    if (Reset) begin
      m_mode = 0; m_t = 0; m_dm = 4; m_db = 4; m_f = 64;
      m_pend = 0; m_fs = 0; m_prevb = 0; m_sok = 0;
      return;
    end
    bnd  = (m_mode != 0) && (m_t == m_dm * m_db * m_f - 1);
    acc  = cfg_valid && !m_pend;
    prom = m_pend && ((m_mode == 0) || bnd);
    case (m_mode)
      0:       nxt = en ? 1 : 0;
      1:       nxt = en ? 1 : 2;
      default: nxt = en ? 1 : (bnd ? 0 : 2);
    endcase
    m_fs = ((m_mode == 0) && en) || (bnd && (nxt != 0));
    if ((nxt == 0) || (m_mode == 0) || bnd) m_t = 0;
    else m_t = m_t + 1;
    if (prom) begin
      m_dm = s_dm; m_db = s_db; m_f = s_f; m_pend = 0;
    end else if (acc) begin
      s_dm = clampd(int'(mclk_div)); s_db = clampd(int'(bclk_div)); s_f = clampf(int'(frame_len));
      m_pend = 1;
    end
    m_mode  = nxt;
    m_prevb = curb;
    m_sok   = 1;
  endtask

  task automatic tick();
    @(posedge clock_in);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic grab(input int n, output logic [15:0] p);
    p = '0;
    for (int i = 0; i < n; i++) begin
      p = {p[14:0], mclk_out};
      tick();
    end
  endtask

  task automatic offer_cfg();
    cfg_valid = 1'b1; mclk_div = 16'd6; bclk_div = 16'd3; frame_len = 8'd4;
  endtask

  typedef struct {
    logic       rst, e, cv;
    int         md, bd, fl;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic e, input logic cv,
                              input int md, input int bd, input int fl, input logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.e = e; v.cv = cv; v.md = md; v.bd = bd; v.fl = fl; v.exp = exp;
    return v;
  endfunction

  vec_t        tbl[25];
  logic [7:0]  run_codes[20];
  logic [15:0] p;
  int          t, cnt, e1, e2, e3, next_rise, lr_first;

  initial begin
    // Divisors 5/1/3 -> effective 5/2/2: MCLK low 2 high 3, BCLK 10 cycles, frame 20.
    run_codes = '{8'hC0, 8'hD0, 8'hD0, 8'hD0, 8'hCA, 8'hC8, 8'hD8, 8'hD8, 8'hD8, 8'hC5,
                  8'hC4, 8'hD4, 8'hD4, 8'hD4, 8'hCE, 8'hCC, 8'hDC, 8'hDC, 8'hDC, 8'hE1};
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 8'h80);
    tbl[1] = mk(0, 0, 1, 5, 1, 3, 8'h00);
    tbl[2] = mk(0, 0, 0, 5, 1, 3, 8'h80);
    tbl[3] = mk(0, 1, 0, 5, 1, 3, 8'hE0);
    for (int i = 0; i < 20; i++) tbl[4 + i] = mk(0, 1, 0, 5, 1, 3, run_codes[i]);
    tbl[24] = mk(0, 0, 0, 5, 1, 3, 8'hC0);

    for (int i = 0; i < 25; i++) begin
      Reset = tbl[i].rst; en = tbl[i].e; cfg_valid = tbl[i].cv;
      mclk_div = 16'(tbl[i].md); bclk_div = 16'(tbl[i].bd); frame_len = 8'(tbl[i].fl);
      tick();
      check($sformatf("vec%0d", i), dut_out, tbl[i].exp);
    end
    cfg_valid = 1'b0;

    // Defaults: patterns, periods, then en dropped at frame cycle 10.
    do_reset();
    check("reset_state", dut_out, 8'h80);
    en = 1'b1; tick(); t = 0;
    check("start_strobe", {running, frame_start, mclk_out, bclk_out, lrclk_out}, 5'b11000);
    grab(8, p); t = 8;
    check("dflt_mclk", p[7:0], 8'b00110011);
    check("dflt_bclk_rise", bclk_rise, 1'b1);
    next_rise = -1; lr_first = -1; e1 = 0; e2 = 0;
    while (t < 1023) begin
      if (t == 10) en = 1'b0;
      tick(); t++;
      if (bclk_rise && next_rise < 0) next_rise = t;
      if (lrclk_out && lr_first < 0) lr_first = t;
      if (!running) e1++;
      if (frame_start) e2++;
    end
    check("bclk_period", next_rise, 24);
    check("lrclk_high_start", lr_first, 512);
    check("stop_running", e1, 0);
    check("stop_no_fs", e2, 0);
    tick();
    check("stop_idle", {running, frame_start, mclk_out, bclk_out, lrclk_out}, 5'b0);
    repeat (5) tick();
    check("idle_quiet", {running, frame_start, mclk_out, bclk_out, lrclk_out}, 5'b0);

    // Configuration offered at frame cycle 300 while running.
    do_reset();
    en = 1'b1; tick(); t = 0; e1 = 0; e2 = 0; e3 = 0;
    while (t < 1023) begin
      if (t == 300) offer_cfg();
      tick(); t++;
      cfg_valid = 1'b0;
      if (cfg_ready !== (t <= 300)) e1++;
      if (mclk_out !== ((t % 4) >= 2)) e2++;
      if (frame_start) e3++;
    end
    check("midframe_ready", e1, 0);
    check("midframe_old_timing", e2, 0);
    check("midframe_no_fs", e3, 0);
    tick();
    check("apply_fs", frame_start, 1'b1);
    check("apply_ready", cfg_ready, 1'b1);
    grab(12, p); cnt = 12;
    check("new_mclk", p[11:0], 12'b000111000111);
    while (!frame_start && cnt < 500) begin tick(); cnt++; end
    check("new_frame_len", cnt, 72);

    // Reset mid-frame with a pending shadow.
    do_reset();
    en = 1'b1; tick(); t = 0;
    while (t < 500) begin
      if (t == 200) offer_cfg();
      tick(); t++;
      cfg_valid = 1'b0;
    end
    check("pend_before_rst", cfg_ready, 1'b0);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("rst_mid_frame", dut_out, 8'h80);
    tick();
    check("restart_fs", {running, frame_start}, 2'b11);
    grab(8, p);
    check("restart_mclk", p[7:0], 8'b00110011);
    check("restart_bclk_rise", bclk_rise, 1'b1);

    // Offer on the boundary cycle applies one frame later.
    do_reset();
    en = 1'b1; tick(); t = 0;
    while (t < 1023) begin tick(); t++; end
    offer_cfg(); tick(); cfg_valid = 1'b0;
    check("bnd_accept", {cfg_ready, frame_start}, 2'b01);
    grab(8, p); cnt = 8;
    check("bnd_old_timing", p[7:0], 8'b00110011);
    while (!frame_start && cnt < 2000) begin tick(); cnt++; end
    check("bnd_frame_len", cnt, 1024);
    check("bnd_ready_back", cfg_ready, 1'b1);
    grab(12, p);
    check("bnd_new_mclk", p[11:0], 12'b000111000111);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 39) == 0);
      mclk_div  = 16'($urandom_range(0, 5));
      bclk_div  = 16'($urandom_range(0, 4));
      frame_len = 8'($urandom_range(0, 6));
      tick();
      check($sformatf("rand%0d", i), dut_out, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
